// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry architectural register file for the 5-stage MIPS pipeline.
// Selects the write-back value, commits it, and serves two ID read ports with write-through bypass.
module wb_regfile #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             control_wb_in,
    input  logic [DATA_WIDTH-1:0]  Read_data_in,
    input  logic [DATA_WIDTH-1:0]  ALU_result_in,
    input  logic [ADDR_WIDTH-1:0]  Write_reg_in,
    input  logic [ADDR_WIDTH-1:0]  Read_reg1,
    input  logic [ADDR_WIDTH-1:0]  Read_reg2,
    output logic [DATA_WIDTH-1:0]  Read_data1,
    output logic [DATA_WIDTH-1:0]  Read_data2,
    output logic [DATA_WIDTH-1:0]  wb_Write_data,
    output logic                   wb_RegWrite,
    output logic [COUNT_WIDTH-1:0] retire_count
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
    logic [COUNT_WIDTH-1:0] retire_count_q;
    logic [COUNT_WIDTH-1:0] retire_count_d;

    logic reg_write;
    logic mem_to_reg;
    logic write_en;

    assign reg_write  = control_wb_in[1];
    assign mem_to_reg = control_wb_in[0];

    // Writes to r0 are dropped here so neither storage nor the counter ever sees them.
    assign write_en = reset && reg_write && (Write_reg_in != '0);

    always_comb begin
        wb_Write_data = ALU_result_in;
        if (mem_to_reg) begin
            wb_Write_data = Read_data_in;
        end
    end

    assign wb_RegWrite = write_en;

    always_comb begin
        regs_d         = regs_q;
        retire_count_d = retire_count_q;
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_d[i] = '0;
            end
            retire_count_d = '0;
        end else if (write_en) begin
            regs_d[Write_reg_in] = wb_Write_data;
            retire_count_d       = retire_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        regs_q         <= regs_d;
        retire_count_q <= retire_count_d;
    end

    // Bypass lets an ID read in the same cycle as the WB write see the new value.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        val = '0;
        if (addr == '0) begin
            val = '0;
        end else if (write_en && (addr == Write_reg_in)) begin
            val = wb_Write_data;
        end else begin
            val = regs_q[addr];
        end
        return val;
    endfunction

    always_comb begin
        Read_data1 = '0;
        Read_data2 = '0;
        if (reset) begin
            Read_data1 = read_port(Read_reg1);
            Read_data2 = read_port(Read_reg2);
        end
    end

    assign retire_count = retire_count_q;

endmodule
